// File: rtl/dcache_tag_array.sv
// D-cache tag store: WAYS dual-port banks of {valid,tag} entries.
// Port B serves load/store lookups with a 1-cycle hit result.
// Port A serves fills, tag-matched external invalidations and the clear sweep.

module tag_bank #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic              a_we_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              a_re_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_re_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Port A write plus synchronous reads on both ports; reads return pre-write contents
  always_ff @(posedge clk) begin
    if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    if (a_re_i) a_rdata_o <= mem_q[a_addr_i];
    if (b_re_i) b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

module dcache_tag_array #(
  parameter int unsigned WAYS            = 2,
  parameter int unsigned LINE_ADDR_W     = 9,
  parameter int unsigned SUB_LINE_ADDR_W = 2,
  parameter int unsigned TAG_W           = 15,
  parameter int unsigned USE_EXT_INV     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_req,
  input  logic [31:0]     lookup_addr,
  output logic            lookup_hit,
  output logic [WAYS-1:0] lookup_hit_way,
  input  logic            fill_req,
  input  logic [31:0]     fill_addr,
  input  logic [WAYS-1:0] fill_way,
  input  logic            inv_valid,
  input  logic [31:0]     inv_addr,
  output logic            inv_ack,
  input  logic            flush_req,
  output logic            flush_done,
  output logic            tags_ready
);

  localparam int unsigned LINE_LSB = 2 + SUB_LINE_ADDR_W;
  localparam bit          INV_EN   = (USE_EXT_INV != 0);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_INV_CHECK,
    ST_FLUSH
  } state_e;

  state_e                 state_q;
  logic [LINE_ADDR_W-1:0] cnt_q;
  logic                   inv_ack_q;
  logic                   flush_done_q;
  logic                   look_req_q;
  logic [TAG_W-1:0]       look_tag_q;

  logic [TAG_W-1:0]       look_tag, fill_tag, inv_tag;
  logic [LINE_ADDR_W-1:0] look_line, fill_line, inv_line;

  logic [LINE_ADDR_W-1:0] a_addr;
  logic [WAYS-1:0]        a_we;
  logic [TAG_W:0]         a_wdata;
  logic                   a_re;
  logic                   b_re;
  logic [TAG_W:0]         a_rdata [WAYS];
  logic [TAG_W:0]         b_rdata [WAYS];
  logic [WAYS-1:0]        inv_match;
  logic                   unused_addr_bits;

  assign look_tag  = lookup_addr[31 -: TAG_W];
  assign fill_tag  = fill_addr[31 -: TAG_W];
  assign inv_tag   = inv_addr[31 -: TAG_W];
  assign look_line = lookup_addr[LINE_LSB +: LINE_ADDR_W];
  assign fill_line = fill_addr[LINE_LSB +: LINE_ADDR_W];
  assign inv_line  = inv_addr[LINE_LSB +: LINE_ADDR_W];

  assign unused_addr_bits = ^{lookup_addr[LINE_LSB-1:0], fill_addr[LINE_LSB-1:0],
                              inv_addr[LINE_LSB-1:0]};

  assign tags_ready = (state_q == ST_IDLE) || (state_q == ST_INV_CHECK);
  assign b_re       = lookup_req & tags_ready;
  assign inv_ack    = inv_ack_q;
  assign flush_done = flush_done_q;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    tag_bank #(
      .ADDR_W (LINE_ADDR_W),
      .DATA_W (TAG_W + 1)
    ) u_bank (
      .clk       (clk),
      .a_addr_i  (a_addr),
      .a_we_i    (a_we[g]),
      .a_wdata_i (a_wdata),
      .a_re_i    (a_re),
      .a_rdata_o (a_rdata[g]),
      .b_addr_i  (look_line),
      .b_re_i    (b_re),
      .b_rdata_o (b_rdata[g])
    );
  end

  // Ways whose stored entry is valid and matches the invalidation tag
  always_comb begin
    inv_match = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      inv_match[w] = a_rdata[w][TAG_W] && (a_rdata[w][TAG_W-1:0] == inv_tag);
    end
  end

  // Port A arbitration: sweep, fill, invalidation read, invalidation write
  always_comb begin
    a_addr  = '0;
    a_we    = '0;
    a_wdata = '0;
    a_re    = 1'b0;
    unique case (state_q)
      ST_INIT, ST_FLUSH: begin
        a_addr = cnt_q;
        a_we   = '1;
      end
      ST_IDLE: begin
        if (flush_req) begin
          a_addr = '0;
        end else if (fill_req) begin
          a_addr  = fill_line;
          a_we    = fill_way;
          a_wdata = {1'b1, fill_tag};
        end else if (INV_EN && inv_valid) begin
          a_addr = inv_line;
          a_re   = 1'b1;
        end
      end
      ST_INV_CHECK: begin
        // A fill wins the port; the compare is dropped and the held request re-issues from IDLE
        if (fill_req) begin
          a_addr  = fill_line;
          a_we    = fill_way;
          a_wdata = {1'b1, fill_tag};
        end else begin
          a_addr = inv_line;
          a_we   = inv_match;
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake pulses and lookup request/tag capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      inv_ack_q    <= 1'b0;
      flush_done_q <= 1'b0;
      look_req_q   <= 1'b0;
      look_tag_q   <= '0;
    end else begin
      inv_ack_q    <= 1'b0;
      flush_done_q <= 1'b0;
      look_req_q   <= b_re;
      look_tag_q   <= look_tag;
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end else if (!fill_req && INV_EN && inv_valid) begin
            state_q <= ST_INV_CHECK;
          end
        end
        ST_INV_CHECK: begin
          state_q <= ST_IDLE;
          if (!fill_req) inv_ack_q <= 1'b1;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Per-way hit from the registered request/tag against the port B read data
  always_comb begin
    lookup_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      lookup_hit_way[w] = look_req_q && b_rdata[w][TAG_W] && (b_rdata[w][TAG_W-1:0] == look_tag_q);
    end
    lookup_hit = |lookup_hit_way;
  end

  a_no_fill_in_sweep: assert property (@(posedge clk) disable iff (!rst)
    ((state_q == ST_INIT) || (state_q == ST_FLUSH)) |-> !fill_req);

  a_fill_way_onehot: assert property (@(posedge clk) disable iff (!rst)
    (fill_req && tags_ready) |-> $onehot(fill_way));

  a_single_way_hit: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(lookup_hit_way));

endmodule

// File: tb/tb_dcache_tag_array.sv
// Directed bench for dcache_tag_array with 16 lines, 2 ways, 24-bit tags.

module tb_dcache_tag_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_req;
  logic [31:0] lookup_addr;
  logic        lookup_hit;
  logic [1:0]  lookup_hit_way;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic [1:0]  fill_way;
  logic        inv_valid;
  logic [31:0] inv_addr;
  logic        inv_ack;
  logic        flush_req;
  logic        flush_done;
  logic        tags_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  dcache_tag_array #(
    .WAYS            (2),
    .LINE_ADDR_W     (4),
    .SUB_LINE_ADDR_W (2),
    .TAG_W           (24),
    .USE_EXT_INV     (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_req     (lookup_req),
    .lookup_addr    (lookup_addr),
    .lookup_hit     (lookup_hit),
    .lookup_hit_way (lookup_hit_way),
    .fill_req       (fill_req),
    .fill_addr      (fill_addr),
    .fill_way       (fill_way),
    .inv_valid      (inv_valid),
    .inv_addr       (inv_addr),
    .inv_ack        (inv_ack),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .tags_ready     (tags_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [1:0] way);
    fill_req  = 1'b1;
    fill_addr = addr;
    fill_way  = way;
    tick();
    fill_req  = 1'b0;
  endtask

  task automatic do_lookup(input string nm, input logic [31:0] addr,
                           input logic exp_hit, input logic [1:0] exp_way);
    lookup_req  = 1'b1;
    lookup_addr = addr;
    tick();
    lookup_req  = 1'b0;
    chk({nm, "_hit"}, lookup_hit, exp_hit);
    chk({nm, "_way"}, lookup_hit_way, exp_way);
  endtask

  // Called in the first cycle of an INIT sweep: 16 not-ready cycles, then ready
  task automatic check_init_sweep(input string nm);
    chk({nm, "_ready0"}, tags_ready, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk({nm, "_ready_low"}, tags_ready, 1'b0);
      chk({nm, "_no_fdone"}, flush_done, 1'b0);
    end
    tick();
    chk({nm, "_ready_high"}, tags_ready, 1'b1);
    chk({nm, "_no_fdone_end"}, flush_done, 1'b0);
  endtask

  initial begin
    rst         = 1'b0;
    lookup_req  = 1'b0;
    lookup_addr = '0;
    fill_req    = 1'b0;
    fill_addr   = '0;
    fill_way    = '0;
    inv_valid   = 1'b0;
    inv_addr    = '0;
    flush_req   = 1'b0;

    // reset held for 3 cycles
    repeat (3) tick();
    chk("rst_ready", tags_ready, 1'b0);
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_hit_way", lookup_hit_way, 2'b00);
    chk("rst_inv_ack", inv_ack, 1'b0);
    chk("rst_fdone", flush_done, 1'b0);
    rst = 1'b1;
    check_init_sweep("init");

    // fill then lookup on the following cycle
    do_fill(32'h0000_1040, 2'b01);
    do_lookup("lk_1044", 32'h0000_1044, 1'b1, 2'b01);
    do_lookup("lk_2040_miss", 32'h0000_2040, 1'b0, 2'b00);
    tick();
    chk("idle_hit", lookup_hit, 1'b0);

    // invalidate a matching way: ack two cycles after request
    do_fill(32'h0000_2040, 2'b10);
    inv_valid = 1'b1;
    inv_addr  = 32'h0000_2040;
    tick();
    chk("inv_ack_early", inv_ack, 1'b0);
    tick();
    chk("inv_ack", inv_ack, 1'b1);
    inv_valid = 1'b0;
    tick();
    chk("inv_ack_pulse", inv_ack, 1'b0);
    do_lookup("lk_1040_kept", 32'h0000_1040, 1'b1, 2'b01);
    do_lookup("lk_2040_inv", 32'h0000_2040, 1'b0, 2'b00);

    // invalidation with no matching way still acks
    inv_valid = 1'b1;
    inv_addr  = 32'h0000_3040;
    tick();
    tick();
    chk("inv_nomatch_ack", inv_ack, 1'b1);
    inv_valid = 1'b0;
    do_lookup("lk_1040_nomatch", 32'h0000_1040, 1'b1, 2'b01);

    // fill arriving during INV_CHECK delays the ack by two cycles
    do_fill(32'h0000_2040, 2'b10);
    inv_valid = 1'b1;
    inv_addr  = 32'h0000_1040;
    tick();
    chk("invf_ack_m1", inv_ack, 1'b0);
    do_fill(32'h0000_3080, 2'b10);
    chk("invf_ack_m2", inv_ack, 1'b0);
    tick();
    chk("invf_ack_m3", inv_ack, 1'b0);
    tick();
    chk("invf_ack_m4", inv_ack, 1'b1);
    inv_valid = 1'b0;
    do_lookup("lk_3080_fill", 32'h0000_3080, 1'b1, 2'b10);
    do_lookup("lk_1040_gone", 32'h0000_1040, 1'b0, 2'b00);
    do_lookup("lk_2040_w1", 32'h0000_2040, 1'b1, 2'b10);

    // same-line lookup and fill in one cycle returns pre-write contents
    fill_req    = 1'b1;
    fill_addr   = 32'h0000_4040;
    fill_way    = 2'b01;
    lookup_req  = 1'b1;
    lookup_addr = 32'h0000_4040;
    tick();
    fill_req    = 1'b0;
    lookup_req  = 1'b0;
    chk("rbw_hit", lookup_hit, 1'b0);
    do_lookup("lk_4040_after", 32'h0000_4040, 1'b1, 2'b01);

    // flush: 16 sweep cycles, lookups dropped meanwhile, then done pulse
    flush_req   = 1'b1;
    tick();
    lookup_req  = 1'b1;
    lookup_addr = 32'h0000_2040;
    for (int i = 1; i <= 16; i++) begin
      chk("flush_ready_low", tags_ready, 1'b0);
      chk("flush_fdone_low", flush_done, 1'b0);
      tick();
      chk("flush_dropped_hit", lookup_hit, 1'b0);
    end
    lookup_req = 1'b0;
    chk("flush_done", flush_done, 1'b1);
    chk("flush_ready_high", tags_ready, 1'b1);
    flush_req = 1'b0;
    tick();
    chk("flush_done_pulse", flush_done, 1'b0);
    do_lookup("lk_post_flush_2040", 32'h0000_2040, 1'b0, 2'b00);
    do_lookup("lk_post_flush_3080", 32'h0000_3080, 1'b0, 2'b00);
    do_lookup("lk_post_flush_4040", 32'h0000_4040, 1'b0, 2'b00);

    // reset during flush at counter 7 restarts INIT with no flush_done
    do_fill(32'h0000_1040, 2'b01);
    flush_req = 1'b1;
    tick();
    repeat (7) tick();
    rst       = 1'b0;
    flush_req = 1'b0;
    tick();
    chk("midrst_ready", tags_ready, 1'b0);
    chk("midrst_fdone", flush_done, 1'b0);
    rst = 1'b1;
    check_init_sweep("reinit");
    do_lookup("lk_after_reinit", 32'h0000_1040, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
